// File: rtl/seg7_pkg.sv
// Shared encodings for the two-digit multiplexed 7-segment scanner:
// frame states, active-low segment patterns and anode enables.
package seg7_pkg;

   localparam logic [1:0] BLANK0 = 2'd0;
   localparam logic [1:0] SHOW0  = 2'd1;
   localparam logic [1:0] BLANK1 = 2'd2;
   localparam logic [1:0] SHOW1  = 2'd3;

   // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;

   localparam logic [1:0] DIG_OFF   = 2'b11;
   localparam logic [1:0] DIG_UNITS = 2'b10;
   localparam logic [1:0] DIG_TENS  = 2'b01;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_pair_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit common-anode display scanner: frame-synchronous digit update,
// inter-digit blanking and optional leading-zero blanking of the tens digit.
module bcd_display_scan
   import seg7_pkg::*;
#(
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] bcd0,
   input  logic [3:0] bcd1,
   input  logic       load,
   input  logic       lzb_en,
   output logic [6:0] seg,
   output logic [1:0] dig_sel,
   output logic       frame_start
);

   localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          run;
   logic          leaving;
   bcd_pair_t     pending, disp, disp_nxt, captured;
   logic [3:0]    dec_digit;
   logic [6:0]    dec_seg;
   logic [6:0]    seg_nxt;
   logic [1:0]    dig_nxt;

   assign captured = '{tens: bcd1, units: bcd0};

   always_comb begin
      state_nxt = state;
      unique case (state)
         BLANK0:  if (cnt == BLANK_LAST) state_nxt = SHOW0;
         SHOW0:   if (cnt == SHOW_LAST)  state_nxt = BLANK1;
         BLANK1:  if (cnt == BLANK_LAST) state_nxt = SHOW1;
         default: if (cnt == SHOW_LAST)  state_nxt = BLANK0;
      endcase
      cnt_nxt = (state_nxt != state) ? '0 : cnt + 1'b1;
      leaving = (state == SHOW1) && (state_nxt == BLANK0);
      // The edge after reset release holds cycle 0 of BLANK0 so that the
      // first visible cycle carries frame_start.
      if (!run) begin
         state_nxt = BLANK0;
         cnt_nxt   = '0;
         leaving   = 1'b0;
      end
   end

   // A load coinciding with the frame boundary bypasses the pending register.
   always_comb begin
      disp_nxt = disp;
      if (leaving) disp_nxt = load ? captured : pending;
   end

   assign dec_digit = (state_nxt == SHOW1) ? disp_nxt.tens : disp_nxt.units;

   bcd_to_seg7 u_dec (
      .digit (dec_digit),
      .seg   (dec_seg)
   );

   // Outputs are decoded from the next state so the flops line up with it.
   always_comb begin
      seg_nxt = SEG_OFF;
      dig_nxt = DIG_OFF;
      unique case (state_nxt)
         SHOW0: begin
            seg_nxt = dec_seg;
            dig_nxt = DIG_UNITS;
         end
         SHOW1: begin
            if (!(lzb_en && disp_nxt.tens == 4'd0)) begin
               seg_nxt = dec_seg;
               dig_nxt = DIG_TENS;
            end
         end
         default: begin
            seg_nxt = SEG_OFF;
            dig_nxt = DIG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= BLANK0;
         cnt         <= '0;
         run         <= 1'b0;
         pending     <= '0;
         disp        <= '0;
         seg         <= SEG_OFF;
         dig_sel     <= DIG_OFF;
         frame_start <= 1'b0;
      end else begin
         run         <= 1'b1;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         if (load) pending <= captured;
         disp        <= disp_nxt;
         seg         <= seg_nxt;
         dig_sel     <= dig_nxt;
         frame_start <= (state_nxt == BLANK0) && (cnt_nxt == '0);
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with a 12-cycle frame (PRESCALE=4, BLANK_CYCLES=2).
module tb_bcd_display_scan;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] bcd0 = 4'd0;
   logic [3:0] bcd1 = 4'd0;
   logic       load = 1'b0;
   logic       lzb_en = 1'b0;
   logic [6:0] seg;
   logic [1:0] dig_sel;
   logic       frame_start;

   bcd_display_scan #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bcd0        (bcd0),
      .bcd1        (bcd1),
      .load        (load),
      .lzb_en      (lzb_en),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       fs;
      logic [1:0] dig;
      logic [6:0] seg;
   } exp_t;

   exp_t  q[$];
   int    errors = 0;
   int    checks = 0;
   int    cur = 0;
   int    ecyc = 0;
   string tname = "none";

   // Monitor: compares one expected entry per cycle while the queue holds any.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (frame_start !== e.fs || dig_sel !== e.dig || seg !== e.seg) begin
            errors++;
            $display("FAIL %s cyc=%0d got fs=%b dig=%b seg=%h want fs=%b dig=%b seg=%h",
                     tname, e.cyc, frame_start, dig_sel, seg, e.fs, e.dig, e.seg);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic push(input logic fs, input logic [1:0] dig, input logic [6:0] sg);
      exp_t e;
      e.cyc = ecyc; e.fs = fs; e.dig = dig; e.seg = sg;
      q.push_back(e);
      ecyc++;
   endtask

   // One full 12-cycle frame: units shown on cycles 2-5, tens on 8-11.
   task automatic push_frame(input logic [6:0] useg, input logic [1:0] tdig, input logic [6:0] tseg);
      push(1'b1, 2'b11, 7'h7F);
      push(1'b0, 2'b11, 7'h7F);
      for (int i = 0; i < 4; i++) push(1'b0, 2'b10, useg);
      for (int i = 0; i < 2; i++) push(1'b0, 2'b11, 7'h7F);
      for (int i = 0; i < 4; i++) push(1'b0, tdig, tseg);
   endtask

   // Hold reset for one edge, release, and queue the reset-state cycle.
   task automatic start_test(input string name);
      tname = name;
      rst_n = 1'b0;
      load  = 1'b0;
      step();
      rst_n = 1'b1;
      cur   = -1;
      ecyc  = -1;
      push(1'b0, 2'b11, 7'h7F);
   endtask

   task automatic load_at(input int c, input logic [3:0] t, input logic [3:0] u);
      while (cur < c) step();
      bcd1 = t;
      bcd0 = u;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         step();
         n++;
      end
      if (q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL %s drain timeout remaining=%0d want 0", tname, q.size());
         q.delete();
      end
   endtask

   initial begin
      repeat (3) step();

      start_test("no_load");
      for (int f = 0; f < 3; f++) push_frame(7'h40, 2'b01, 7'h40);
      drain();

      start_test("load_42");
      push_frame(7'h40, 2'b01, 7'h40);
      push_frame(7'h24, 2'b01, 7'h19);
      load_at(3, 4'd4, 4'd2);
      drain();

      start_test("last_wins");
      push_frame(7'h40, 2'b01, 7'h40);
      push_frame(7'h12, 2'b01, 7'h30);
      load_at(5, 4'd9, 4'd7);
      load_at(9, 4'd3, 4'd5);
      drain();

      start_test("bypass");
      push_frame(7'h40, 2'b01, 7'h40);
      push_frame(7'h02, 2'b01, 7'h79);
      push_frame(7'h02, 2'b01, 7'h79);
      load_at(11, 4'd1, 4'd6);
      drain();

      lzb_en = 1'b1;
      start_test("lzb");
      push_frame(7'h40, 2'b11, 7'h7F);
      push_frame(7'h00, 2'b11, 7'h7F);
      push_frame(7'h00, 2'b01, 7'h3F);
      load_at(0, 4'd0, 4'd8);
      load_at(14, 4'hB, 4'd8);
      drain();
      lzb_en = 1'b0;

      start_test("mid_reset");
      push_frame(7'h40, 2'b01, 7'h40);
      push(1'b1, 2'b11, 7'h7F);
      push(1'b0, 2'b11, 7'h7F);
      for (int i = 0; i < 3; i++) push(1'b0, 2'b10, 7'h24);
      push(1'b0, 2'b11, 7'h7F);
      push_frame(7'h40, 2'b01, 7'h40);
      push_frame(7'h40, 2'b01, 7'h40);
      load_at(3, 4'd4, 4'd2);
      while (cur < 16) step();
      // Reset coincides with a load of 5/5; nothing may be captured.
      rst_n = 1'b0;
      bcd1  = 4'd5;
      bcd0  = 4'd5;
      load  = 1'b1;
      step();
      rst_n = 1'b1;
      load  = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the 7-bit binary-to-BCD converter's two BCD digits.
- Captures tens/units digits on a load strobe and drives a two-digit, common-anode, time-multiplexed 7-segment display.
- Behaviour: frame-synchronous update (no tearing), inter-digit blanking (anti-ghosting), optional leading-zero blanking.
- Sits between the converter and the board HEX/anode pins.

Parameters:
- PRESCALE, 50000: cycles each digit is lit per frame; must be >= 2.
- BLANK_CYCLES, 500: cycles both digits are dark before each digit phase; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- bcd0  in  4  units digit from the converter.
- bcd1  in  4  tens digit from the converter.
- load  in  1  capture strobe; bcd0/bcd1 are sampled on any edge where load=1.
- lzb_en  in  1  1 = blank the tens digit when it is 0.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- dig_sel  out  2  anode enables, active-low; [0]=units, [1]=tens; registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n. Sampled only on the rising edge of clk.
- Reset values, taking effect at the first edge with rst_n=0, including mid-frame:
  - seg=7'h7F, dig_sel=2'b11, frame_start=0.
  - pending and display regs = 0; state=BLANK0; phase counter=0.
- Frame FSM (cyclic):
  - BLANK0 for BLANK_CYCLES cycles.
  - SHOW0 for PRESCALE cycles.
  - BLANK1 for BLANK_CYCLES cycles.
  - SHOW1 for PRESCALE cycles, then back to BLANK0.
  - Frame period = 2*(PRESCALE+BLANK_CYCLES). The phase counter clears on every state change.
- First frame: the first cycle after rst_n returns high is cycle 0 of BLANK0. frame_start=1 on that cycle and on cycle 0 of every subsequent BLANK0.
- Outputs by state; seg/dig_sel are registered so they match the state in the same cycle:
  - BLANK0, BLANK1: dig_sel=2'b11, seg=7'h7F.
  - SHOW0: dig_sel=2'b10, seg=decode(disp0).
  - SHOW1: dig_sel=2'b01, seg=decode(disp1).
  - SHOW1 exception: if lzb_en=1 and disp1=0, dig_sel=2'b11 and seg=7'h7F.
  - lzb_en is sampled live each cycle.
- Capture and update:
  - Edge with load=1: pending <= {bcd1,bcd0}.
  - Edge leaving SHOW1 (entering BLANK0): disp <= pending.
  - Simultaneous load on that edge: bypass, disp <= {bcd1,bcd0} directly, and pending also takes the new value.
  - Loads mid-frame never change the digits being shown until the next frame boundary. The last load before the boundary wins.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Inputs 10-15 are invalid BCD and display a dash, 3F.
  - The dash is not subject to leading-zero blanking.
- Width/counter rules:
  - Phase counter width = clog2(max(PRESCALE,BLANK_CYCLES)).
  - Counter compares against PARAM-1; no wrap other than the FSM-directed clear.
- Reset asserted while load=1: reset wins; nothing is captured.

Decomposition:
- Shared package/include seg7_pkg:
  - state encoding (BLANK0, SHOW0, BLANK1, SHOW1);
  - SEG_OFF=7'h7F, SEG_DASH=7'h3F;
  - digit segment constants 0-9;
  - DIG_OFF=2'b11.
- One sub-module: bcd_to_seg7, a combinational 4-bit to 7-bit active-low decoder, instanced once on a muxed digit.
- The top holds the FSM, phase counter, pending/display registers and output flops.

Test Plan:
All scenarios use PRESCALE=4, BLANK_CYCLES=2, giving a 12-cycle frame.
- Reset release, no load -> frame_start on cycles 0, 12, 24. Cycles 0-1: 11/7F. Cycles 2-5: dig_sel=10, seg=40. Cycles 6-7: dark. Cycles 8-11: dig_sel=01, seg=40.
- load with bcd1=4, bcd0=2 at cycle 3 -> frame 0 still shows 0/0. From cycle 14: units seg=24. From cycle 20: tens seg=19.
- load 9/7 at cycle 5, then 3/5 at cycle 9 -> frame 1 shows units 12, tens 30; 9/7 is never displayed.
- load 1/6 on the edge ending cycle 11 (bypass) -> cycle 14 seg=02, cycle 20 seg=79.
- lzb_en=1 with digits 0/8 -> SHOW1 stays dig_sel=11, seg=7F. With digit 0xB in tens: SHOW1 seg=3F, dig_sel=01.
- rst_n=0 for one edge during SHOW0 (cycle 4) -> next cycle outputs 11/7F and displayed digits revert to 0. Restart BLANK0 with frame_start=1 on the first cycle after release.
